// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl : multiply/divide unit control with architectural HI/LO registers.
//
// Results are computed in one shot when an operation starts and are parked in
// pending registers. A down-counter then models the multi-cycle latency. HI/LO
// are updated only when the counter expires, so software sees the old values
// for the whole time busy is high.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   reset_n   in   asynchronous active-low reset
//   md_en     in   E-stage instruction is mult/div/mthi/mtlo
//   md_op     in   [2:0] 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                        100 MTHI, 101 MTLO, 11x reserved (no-op)
//   a, b      in   [31:0] forwarded E-stage rs / rt operands
//   d_md_use  in   D-stage instruction touches the MDU (incl. mfhi/mflo)
//   busy      out  multi-cycle operation in progress
//   stall     out  combinational stall request for the hazard unit
//   hi, lo    out  [31:0] architectural HI / LO
//
// Build option
//   MDU_DIV0_HOLD_EN  when defined, DIV/DIVU by zero completes after one cycle
//                     and leaves HI/LO unchanged. When undefined, divide by
//                     zero takes the full divide latency and writes
//                     HI = dividend, LO = all ones.
// -----------------------------------------------------------------------------
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        md_en,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  localparam logic [3:0] N_MUL  = 4'd5;
  localparam logic [3:0] N_DIV  = 4'd10;
`ifdef MDU_DIV0_HOLD_EN
  localparam logic [3:0] N_DIV0 = 4'd1;
`endif

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  logic        start;
  logic        is_div;
  logic        op_sgn;
  logic        div0;
  logic [63:0] mul_res;
  logic [63:0] div_res;

  // Operands are widened by one bit (sign or zero) so a single signed
  // multiplier covers both MULT and MULTU.
  function automatic logic [63:0] mult64(input logic [31:0] x, input logic [31:0] y,
                                         input logic sgn);
    logic signed [32:0] xe;
    logic signed [32:0] ye;
    logic signed [65:0] p;
    xe = {sgn & x[31], x};
    ye = {sgn & y[31], y};
    p  = xe * ye;
    return p[63:0];
  endfunction

  // Returns {remainder, quotient}. The 33-bit signed divide avoids the
  // -2^31 / -1 overflow and truncates toward zero, so the remainder carries
  // the dividend's sign. The caller never uses the result when y is zero.
  function automatic logic [63:0] divmod(input logic [31:0] x, input logic [31:0] y,
                                         input logic sgn);
    logic signed [32:0] xe;
    logic signed [32:0] ye;
    logic signed [32:0] q;
    logic signed [32:0] r;
    xe = {sgn & x[31], x};
    ye = {sgn & y[31], y};
    q  = xe / ye;
    r  = xe % ye;
    return {r[31:0], q[31:0]};
  endfunction

  assign is_div  = md_op[1];
  assign op_sgn  = ~md_op[0];
  assign div0    = is_div & (b == 32'd0);
  assign mul_res = mult64(a, b, op_sgn);
  assign div_res = divmod(a, b, op_sgn);

  assign start = md_en & ~md_op[2] & (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  // reset_n gates the start term so no stall escapes while reset is held.
  assign stall = d_md_use & (busy | (start & reset_n));
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          pend_wr_d = 1'b1;
          if (!is_div) begin
            {pend_hi_d, pend_lo_d} = mul_res;
            cnt_d = N_MUL;
          end else if (div0) begin
`ifdef MDU_DIV0_HOLD_EN
            cnt_d     = N_DIV0;
            pend_wr_d = 1'b0;
`else
            cnt_d     = N_DIV;
            pend_hi_d = a;
            pend_lo_d = 32'hFFFF_FFFF;
`endif
          end else begin
            {pend_hi_d, pend_lo_d} = div_res;
            cnt_d = N_DIV;
          end
        end else if (md_en && (md_op == OP_MTHI)) begin
          hi_d = a;
        end else if (md_en && (md_op == OP_MTLO)) begin
          lo_d = a;
        end
      end
      default: begin
        // Any md_en while running is ignored; only the counter advances.
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl : self-checking bench for mdu_ctrl.
// Directed vector table, hand-written corner sequences (MTHI/MTLO, reserved
// ops, intrusion while running, reset abort) and a randomized stream checked
// against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        md_en;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  // Architectural HI/LO as the bench believes them to be.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .md_en    (md_en),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        du;
    int          n;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] ph, input logic [31:0] pl,
                                output logic [31:0] eh, output logic [31:0] el, output int n);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    eh = ph;
    el = pl;
    n  = 10;
    if (op == 3'd0) begin
      q = sx * sy;
      {eh, el} = q;
      n = 5;
    end else if (op == 3'd1) begin
      uq = ux * uy;
      {eh, el} = uq;
      n = 5;
    end else if (y == 32'd0) begin
`ifdef MDU_DIV0_HOLD_EN
      n = 1;
`else
      eh = x;
      el = 32'hFFFF_FFFF;
`endif
    end else if (op == 3'd2) begin
      q  = sx / sy;
      r  = sx % sy;
      el = q[31:0];
      eh = r[31:0];
    end else begin
      uq = ux / uy;
      ur = ux % uy;
      el = uq[31:0];
      eh = ur[31:0];
    end
  endfunction

  // Issue one mult/div, follow it to completion and check latency, stall,
  // HI/LO hold while busy and the final HI/LO. With intrude set, md_en stays
  // high during RUN alternating MTLO and MULT requests that must be ignored.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] oa,
                        input logic [31:0] ob, input logic du, input int en,
                        input logic [31:0] eh, input logic [31:0] el, input logic intrude);
    int cyc;
    int stc;
    cyc = 0;
    stc = 0;
    @(negedge clk);
    md_en = 1'b1; md_op = op; a = oa; b = ob; d_md_use = du;
    #1;
    chk({nm, ".stall_start"}, 64'(stall), 64'(du));
    @(posedge clk); #1;
    md_en = intrude;
    md_op = 3'b101;
    a = $urandom; b = $urandom;
    while (busy && cyc < 40) begin
      if (cyc == 0) begin
        chk({nm, ".hi_hold"}, 64'(hi), 64'(m_hi));
        chk({nm, ".lo_hold"}, 64'(lo), 64'(m_lo));
      end
      cyc++;
      if (stall) stc++;
      md_op = (cyc % 2 == 1) ? 3'b000 : 3'b101;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    md_en = 1'b0;
    #1;
    chk({nm, ".busy_cycles"}, 64'(cyc), 64'(en));
    chk({nm, ".stall_cycles"}, 64'(stc), du ? 64'(en) : 64'd0);
    chk({nm, ".stall_after"}, 64'(stall), 64'd0);
    chk({nm, ".hi"}, 64'(hi), 64'(eh));
    chk({nm, ".lo"}, 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic [2:0]  rop;
    int          n;

    vt[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,        1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vt[1] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[2] = '{3'd3, 32'd7,         32'd2,        1'b0, 10, 32'd1,         32'd3};
    vt[3] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5, 32'hFFFF_FFFE, 32'h0000_0001};
`ifdef MDU_DIV0_HOLD_EN
    vt[4] = '{3'd3, 32'd5,         32'd0,        1'b1, 1,  32'hFFFF_FFFE, 32'h0000_0001};
`else
    vt[4] = '{3'd3, 32'd5,         32'd0,        1'b1, 10, 32'd5,         32'hFFFF_FFFF};
`endif
    vt[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0,        32'h8000_0000};
    vt[6] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 5, 32'h4000_0000, 32'h0000_0000};
    vt[7] = '{3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 10, 32'hFFFF_FFFF, 32'd3};

    // Reset state, with a would-be start and D-stage use present.
    reset_n = 1'b0; md_en = 1'b1; md_op = 3'd0; a = 32'd2; b = 32'd3; d_md_use = 1'b1;
    #2;
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; md_en = 1'b0; d_md_use = 1'b0;

    // Directed table, issued back to back.
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].du, vt[i].n,
             vt[i].eh, vt[i].el, 1'b0);

    // MTHI in IDLE.
    @(negedge clk);
    md_en = 1'b1; md_op = 3'b100; a = 32'h1234_5678; d_md_use = 1'b1;
    #1;
    chk("mthi.stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    md_en = 1'b0;
    chk("mthi.hi", 64'(hi), 64'h1234_5678);
    chk("mthi.lo", 64'(lo), 64'(m_lo));
    chk("mthi.busy", 64'(busy), 64'd0);
    m_hi = 32'h1234_5678;

    // MTLO in IDLE.
    @(negedge clk);
    md_en = 1'b1; md_op = 3'b101; a = 32'hCAFE_F00D;
    @(posedge clk); #1;
    md_en = 1'b0;
    chk("mtlo.lo", 64'(lo), 64'hCAFE_F00D);
    chk("mtlo.hi", 64'(hi), 64'(m_hi));
    m_lo = 32'hCAFE_F00D;

    // Reserved encodings change nothing.
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      md_en = 1'b1; md_op = 3'(k); a = $urandom; b = $urandom; d_md_use = 1'b1;
      #1;
      chk($sformatf("rsv%0d.stall", k), 64'(stall), 64'd0);
      @(posedge clk); #1;
      md_en = 1'b0;
      chk($sformatf("rsv%0d.busy", k), 64'(busy), 64'd0);
      chk($sformatf("rsv%0d.hi", k), 64'(hi), 64'(m_hi));
      chk($sformatf("rsv%0d.lo", k), 64'(lo), 64'(m_lo));
    end

    // MTLO / MULT requests while running are ignored.
    run_op("intr_mult", 3'd1, 32'd100, 32'd200, 1'b1, 5, 32'd0, 32'd20000, 1'b1);
    run_op("intr_divu", 3'd3, 32'd1000, 32'd7, 1'b0, 10, 32'd6, 32'd142, 1'b1);

    // Reset in the third busy cycle of a DIV.
    @(negedge clk);
    md_en = 1'b1; md_op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2; d_md_use = 1'b1;
    @(posedge clk); #1;
    md_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0; md_en = 1'b1; md_op = 3'd0;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.hi", 64'(hi), 64'd0);
    chk("abort.lo", 64'(lo), 64'd0);
    chk("abort.stall", 64'(stall), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset_n = 1'b1; md_en = 1'b0;
    run_op("post_rst", 3'd0, 32'd7, 32'd9, 1'b1, 5, 32'd0, 32'd63, 1'b0);

    // Randomized stream against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
            ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      model(rop, ra, rb, m_hi, m_lo, eh, el, n);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'($urandom_range(0, 1)), n, eh, el,
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
